tone_decoder: RTL and testbench

// - Receiving end of the buzzer tone interface: measures the period of an incoming square wave.
// - The square wave is the kind made by the tone generator, whose output toggles every H+1 clocks.
// - It decodes the period back into the one-hot note code plus the octave flags.
// - Sits between an external tone pin (or the generator's pwm, for loopback) and the display/scoring logic.

---
 rtl/tone_decoder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tone_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tone_decoder
//  Description : Measures the period of an incoming square wave (rising edge
//                to rising edge) and decodes it into a one-hot note code plus
//                octave flags. A note is only reported after two consecutive
//                periods match the same table entry.
//
//  Ports       : clk          system clock
//                rst          asynchronous, active-high reset
//                tone_in      asynchronous square wave to decode
//                notes[6:0]   one-hot note, [6]=do ... [0]=si, 0 when invalid
//                ishigher     locked note is in the high octave
//                islower      locked note is in the low octave
//                valid        a note is locked
//                note_change  1-clk pulse when {valid,notes,ishigher,islower}
//                             changes
//
//  Parameters  : TOL_SHIFT    match tolerance = E >> TOL_SHIFT clocks
//                TIMEOUT_CYC  clocks without a rise before declaring silence
//                TABLE_SHIFT  right shift applied to every half-period table
//                             constant (0 = nominal 100 MHz table); lets the
//                             same decoder follow a prescaled tone clock
//
//  Revision    : 1.0  initial release
// ============================================================================
module tone_decoder #(
    parameter int TOL_SHIFT   = 6,
    parameter int TIMEOUT_CYC = 400000,
    parameter int TABLE_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    output logic [6:0] notes,
    output logic       ishigher,
    output logic       islower,
    output logic       valid,
    output logic       note_change
);

    localparam int          c_NUM_NOTES = 21;
    localparam logic [31:0] c_TIMEOUT   = TIMEOUT_CYC[31:0];

    localparam logic [1:0] c_SILENT  = 2'd0;
    localparam logic [1:0] c_ARMED   = 2'd1;
    localparam logic [1:0] c_CONFIRM = 2'd2;
    localparam logic [1:0] c_LOCKED  = 2'd3;

    // Half-period table, index 0..6 = low do..si, 7..13 mid, 14..20 high.
    function automatic logic [31:0] half_period(input int k);
        logic [31:0] h;
        case (k)
            0:       h = 32'd190840;
            1:       h = 32'd170068;
            2:       h = 32'd151515;
            3:       h = 32'd143266;
            4:       h = 32'd127551;
            5:       h = 32'd113636;
            6:       h = 32'd101215;
            7:       h = 32'd95602;
            8:       h = 32'd85179;
            9:       h = 32'd75873;
            10:      h = 32'd71633;
            11:      h = 32'd63776;
            12:      h = 32'd56818;
            13:      h = 32'd50607;
            14:      h = 32'd47801;
            15:      h = 32'd42553;
            16:      h = 32'd37936;
            17:      h = 32'd35791;
            18:      h = 32'd31888;
            19:      h = 32'd28409;
            20:      h = 32'd25304;
            default: h = 32'd0;
        endcase
        return h;
    endfunction

    // The generator toggles every H+1 clocks, so a full period is 2*(H+1).
    function automatic logic [31:0] expected_period(input int k);
        return ((half_period(k) >> TABLE_SHIFT) + 32'd1) << 1;
    endfunction

    // {notes, ishigher, islower} for table index idx.
    function automatic logic [8:0] decode(input logic [4:0] idx);
        logic [4:0] pos;
        logic [1:0] row;
        if (idx < 5'd7) begin
            row = 2'd0;
            pos = idx;
        end else if (idx < 5'd14) begin
            row = 2'd1;
            pos = idx - 5'd7;
        end else begin
            row = 2'd2;
            pos = idx - 5'd14;
        end
        return {7'b1000000 >> pos, row == 2'd2, row == 2'd0};
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic r_sync_q;
    logic r_sync_qq;
    logic w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_q  <= 1'b0;
            r_sync_qq <= 1'b0;
        end else begin
            r_sync_q  <= tone_in;
            r_sync_qq <= r_sync_q;
        end
    end

    assign w_rise = r_sync_q & ~r_sync_qq;

    // ------------------------------------------------------------------
    // Period counter. r_rise_q / r_timeout_q mark the cycle on which the
    // FSM acts; the timeout flag fires only on the transition into
    // saturation, so a long silence followed by a rise still re-arms.
    // ------------------------------------------------------------------
    logic [31:0] r_cnt;
    logic [31:0] r_period;
    logic        r_rise_q;
    logic        r_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 32'd0;
            r_period    <= 32'd0;
            r_rise_q    <= 1'b0;
            r_timeout_q <= 1'b0;
        end else if (w_rise) begin
            r_period    <= r_cnt + 32'd1;
            r_cnt       <= 32'd0;
            r_rise_q    <= 1'b1;
            r_timeout_q <= 1'b0;
        end else begin
            r_rise_q <= 1'b0;
            if (r_cnt != c_TIMEOUT) begin
                r_cnt       <= r_cnt + 32'd1;
                r_timeout_q <= (r_cnt + 32'd1 == c_TIMEOUT);
            end else begin
                r_timeout_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Classifier: one window comparator per table entry, 33-bit absolute
    // difference so that P < E cannot wrap.
    // ------------------------------------------------------------------
    logic [c_NUM_NOTES-1:0] w_match;
    logic [32:0]            w_p_ext;

    assign w_p_ext = {1'b0, r_period};

    for (genvar gi = 0; gi < c_NUM_NOTES; gi++) begin : g_cls
        localparam logic [32:0] c_E   = {1'b0, expected_period(gi)};
        localparam logic [32:0] c_TOL = c_E >> TOL_SHIFT;
        logic [32:0] w_diff;
        assign w_diff      = (w_p_ext >= c_E) ? (w_p_ext - c_E) : (c_E - w_p_ext);
        assign w_match[gi] = (w_diff <= c_TOL);
    end

    // Windows are disjoint, so this encoder sees at most one bit set.
    logic       w_hit;
    logic [4:0] w_idx;

    always_comb begin
        w_hit = 1'b0;
        w_idx = 5'd0;
        for (int k = 0; k < c_NUM_NOTES; k++) begin
            if (w_match[k] && !w_hit) begin
                w_hit = 1'b1;
                w_idx = k[4:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [4:0] r_cand;
    logic [4:0] r_cur;
    logic [9:0] r_out;      // {valid, notes, ishigher, islower}
    logic       r_change;

    logic [1:0] w_state_nx;
    logic [4:0] w_cand_nx;
    logic [4:0] w_cur_nx;
    logic       w_valid_nx;
    logic [9:0] w_out_nx;

    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_cur_nx   = r_cur;
        w_valid_nx = r_out[9];
        if (r_timeout_q) begin
            w_state_nx = c_SILENT;
            w_valid_nx = 1'b0;
        end else if (r_rise_q) begin
            case (r_state)
                c_SILENT: begin
                    // First edge after silence: no period to judge yet.
                    w_state_nx = c_ARMED;
                end
                c_ARMED: begin
                    if (w_hit) begin
                        w_state_nx = c_CONFIRM;
                        w_cand_nx  = w_idx;
                    end
                end
                c_CONFIRM: begin
                    if (!w_hit) begin
                        w_state_nx = c_ARMED;
                        w_valid_nx = 1'b0;
                    end else if (w_idx == r_cand) begin
                        w_state_nx = c_LOCKED;
                        w_cur_nx   = w_idx;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_cand_nx  = w_idx;
                    end
                end
                c_LOCKED: begin
                    if (!w_hit) begin
                        w_state_nx = c_ARMED;
                        w_valid_nx = 1'b0;
                    end else if (w_idx != r_cur) begin
                        // Outputs keep the old note until the new one confirms.
                        w_state_nx = c_CONFIRM;
                        w_cand_nx  = w_idx;
                    end
                end
                default: begin
                    w_state_nx = c_SILENT;
                    w_valid_nx = 1'b0;
                end
            endcase
        end
    end

    assign w_out_nx = w_valid_nx ? {1'b1, decode(w_cur_nx)} : 10'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_SILENT;
            r_cand   <= 5'd0;
            r_cur    <= 5'd0;
            r_out    <= 10'd0;
            r_change <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cand   <= w_cand_nx;
            r_cur    <= w_cur_nx;
            r_out    <= w_out_nx;
            r_change <= (w_out_nx != r_out);
        end
    end

    assign valid       = r_out[9];
    assign notes       = r_out[8:2];
    assign ishigher    = r_out[1];
    assign islower     = r_out[0];
    assign note_change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_tone_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tone_decoder
//  Description : Self-checking bench for tone_decoder. Stimulus is a stream of
//                square-wave periods; a period-level reference model predicts
//                every output change and pushes it into a queue that a monitor
//                pops on each note_change pulse. The table is prescaled so that
//                the run stays short.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tone_decoder;

    localparam int TOL_SHIFT = 6;
    localparam int TIMEOUT   = 1600;
    localparam int TSHIFT    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tone_in;
    logic [6:0] notes;
    logic       ishigher;
    logic       islower;
    logic       valid;
    logic       note_change;

    always #5 clk = ~clk;

    tone_decoder #(
        .TOL_SHIFT   (TOL_SHIFT),
        .TIMEOUT_CYC (TIMEOUT),
        .TABLE_SHIFT (TSHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (tone_in),
        .notes       (notes),
        .ishigher    (ishigher),
        .islower     (islower),
        .valid       (valid),
        .note_change (note_change)
    );

    int H_TAB [21] = '{190840, 170068, 151515, 143266, 127551, 113636, 101215,
                        95602,  85179,  75873,  71633,  63776,  56818,  50607,
                        47801,  42553,  37936,  35791,  31888,  28409,  25304};

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q [$];

    // Reference model: silence flag, note seen on the previous period,
    // and the output word {valid, notes, ishigher, islower}.
    bit         m_silent;
    int         m_prev;
    logic [9:0] m_out;
    int         gap;
    bit         last_lvl;

    function automatic int period_of(input int k);
        return 2 * ((H_TAB[k] >> TSHIFT) + 1);
    endfunction

    function automatic int classify(input int p);
        int e, tol, d;
        for (int k = 0; k < 21; k++) begin
            e   = period_of(k);
            tol = e >> TOL_SHIFT;
            d   = p - e;
            if (d < 0) d = -d;
            if (d <= tol) return k;
        end
        return -1;
    endfunction

    function automatic logic [9:0] pack_of(input int k);
        logic [6:0] n;
        n = 7'b1000000 >> (k % 7);
        return {1'b1, n, (k / 7) == 2, (k / 7) == 0};
    endfunction

    task automatic set_out(input logic [9:0] v);
        if (v !== m_out) begin
            exp_q.push_back(v);
            m_out = v;
        end
    endtask

    task automatic model_timeout();
        if (!m_silent) begin
            m_silent = 1'b1;
            m_prev   = -1;
            set_out(10'd0);
        end
    endtask

    task automatic model_rise(input int g);
        int k;
        if (g > TIMEOUT) model_timeout();
        if (m_silent) begin
            m_silent = 1'b0;
            m_prev   = -1;
            return;
        end
        k = classify(g);
        if (k < 0) begin
            m_prev = -1;
            set_out(10'd0);
        end else if (k == m_prev) begin
            set_out(pack_of(k));
        end else begin
            m_prev = k;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_silent = 1'b1;
        m_prev   = -1;
        m_out    = 10'd0;
        gap      = 0;
        last_lvl = 1'b0;
    endtask

    // One clock of stimulus; the model is told about rises and timeouts.
    task automatic drive(input bit v);
        @(posedge clk);
        #2;
        tone_in = v;
        gap++;
        if (v && !last_lvl) begin
            model_rise(gap);
            gap = 0;
        end else if (gap == TIMEOUT + 1) begin
            model_timeout();
        end
        last_lvl = v;
    endtask

    task automatic check_out(input string name);
        checks++;
        if ({valid, notes, ishigher, islower} !== m_out) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name,
                     {valid, notes, ishigher, islower}, m_out);
        end
    endtask

    task automatic expect_word(input string name, input logic [9:0] want);
        checks++;
        if ({valid, notes, ishigher, islower} !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name,
                     {valid, notes, ishigher, islower}, want);
        end
    endtask

    task automatic send_period(input int p, input string name);
        for (int i = 0; i < p; i++) begin
            drive(i < p / 2);
            if (i == 8) check_out(name);
        end
    endtask

    task automatic silence(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
        check_out("silence");
    endtask

    // Monitor: every note_change pulse must match the next predicted change.
    always @(negedge clk) begin
        if (!rst && note_change) begin
            logic [9:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL note_change: unexpected pulse, outputs %b expected no pulse",
                         {valid, notes, ishigher, islower});
            end else begin
                e = exp_q.pop_front();
                if ({valid, notes, ishigher, islower} !== e) begin
                    errors++;
                    $display("FAIL note_change: got %b expected %b",
                             {valid, notes, ishigher, islower}, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int la_e;
        rst     = 1'b1;
        tone_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_word("reset_outputs", 10'd0);
        checks++;
        if (note_change !== 1'b0) begin
            errors++;
            $display("FAIL reset_note_change: got %b expected 0", note_change);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Mid do, high si, low do
        repeat (4) send_period(period_of(7), "mid_do");
        expect_word("mid_do_lock", {1'b1, 7'b1000000, 1'b0, 1'b0});
        repeat (4) send_period(period_of(20), "high_si");
        expect_word("high_si_lock", {1'b1, 7'b0000001, 1'b1, 1'b0});
        repeat (4) send_period(period_of(0), "low_do");
        expect_word("low_do_lock", {1'b1, 7'b1000000, 1'b0, 1'b1});
        silence(TIMEOUT + 20);
        expect_word("timeout_clear", 10'd0);

        // Tolerance: +1% locks, +3% never validates
        la_e = period_of(5);
        repeat (4) send_period((la_e * 101 + 50) / 100, "la_plus1");
        expect_word("la_plus1_lock", {1'b1, 7'b0000010, 1'b0, 1'b1});
        silence(TIMEOUT + 20);
        repeat (5) send_period((la_e * 103 + 50) / 100, "la_plus3");
        expect_word("la_plus3_invalid", 10'd0);
        silence(TIMEOUT + 20);

        // Locked mid la, then switch to mid sol
        repeat (4) send_period(period_of(12), "mid_la");
        send_period(period_of(11), "sol_first");
        send_period(period_of(11), "sol_second");
        expect_word("switch_hold_la", {1'b1, 7'b0000010, 1'b0, 1'b0});
        send_period(period_of(11), "sol_third");
        expect_word("switch_to_sol", {1'b1, 7'b0000100, 1'b0, 1'b0});
        send_period(period_of(11), "sol_fourth");

        // Asynchronous reset while locked, then relock needs three rises
        @(posedge clk);
        #3;
        rst     = 1'b1;
        tone_in = 1'b0;
        #1;
        expect_word("async_reset", 10'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) send_period(period_of(9), "relock");
        expect_word("relock_two_rises", 10'd0);
        send_period(period_of(9), "relock");
        expect_word("relock_three_rises", {1'b1, 7'b0010000, 1'b0, 1'b0});

        // Randomised note segments with jitter and occasional off-table periods
        for (int s = 0; s < 10; s++) begin
            int k, n, p, e, tol;
            k = int'($urandom_range(0, 20));
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < n; j++) begin
                e   = period_of(k);
                tol = e >> TOL_SHIFT;
                if ($urandom_range(0, 4) == 0)
                    p = int'($urandom_range(200, 1500));
                else
                    p = e - tol / 2 + int'($urandom_range(0, tol));
                send_period(p, "random");
            end
            if ($urandom_range(0, 3) == 0) silence(TIMEOUT + 20);
        end

        silence(TIMEOUT + 20);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_changes: got %0d unseen pulses expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
